restriction_sweep_ctrl: RTL and testbench
=========================================

Name: restriction_sweep_ctrl

Overview:
- Exhaustive-sweep sequencer for a single-output combinational function block with up to 15 inputs.
- Enumerates every input vector consistent with a restriction cube: some inputs fixed to given values, the rest free.
- Drives the function under test (f) and a companion restricted/reference function (g) with the same vector.
- Reports how many vectors give f=1, and how many give f!=g; used to validate restricted and optimised versions against the original.

Parameters:
N_IN, 15, number of function inputs (1..15)
CNT_W, 16, counter width; must be >= N_IN+1

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
start  in  1  begin sweep; honoured only in IDLE
abort  in  1  cancel sweep; honoured only in SWEEP
fix_mask  in  N_IN  1 = input fixed, 0 = free; latched on accepted start
fix_val  in  N_IN  values for fixed inputs; bits where fix_mask=0 ignored; latched on accepted start
x_out  out  N_IN  registered vector driven to both functions
f_in  in  1  function-under-test output; combinational from x_out
g_in  in  1  companion function output; combinational from x_out
busy  out  1  high while in SWEEP
done  out  1  one-cycle pulse after the last vector is counted
ones_cnt  out  CNT_W  number of swept vectors with f_in=1
mism_cnt  out  CNT_W  number of swept vectors with f_in != g_in

Behaviour:
- Reset values: state IDLE; x_out=0, busy=0, done=0, ones_cnt=0, mism_cnt=0; internal free counter=0.
- States: IDLE, SWEEP, DONE. busy = (state==SWEEP); done = (state==DONE). Both are registered.
- IDLE, start=1 at an edge:
  - latch mask M and value V;
  - clear free=0, ones_cnt=0, mism_cnt=0;
  - x_out <= V&M;
  - go to SWEEP.
- SWEEP, each edge with abort=0:
  - ones_cnt += f_in; mism_cnt += f_in^g_in (both evaluated against the current x_out);
  - if free == ~M (all free bits set): go to DONE;
  - else free <= ((free|M)+1) & ~M, and x_out <= next_free | (V&M).
- Enumeration order: ascending binary over free bit positions only; fixed bits never change during a sweep.
- Vector count = 2^(number of zero bits in M). Busy lasts exactly that many cycles. done goes high in the cycle after the last busy cycle.
- DONE: lasts one cycle, then IDLE. Counters and x_out hold until the next accepted start.
- Edge cases:
  - start while busy or in DONE: ignored.
  - start and abort together in IDLE: start wins.
  - abort in SWEEP: go to IDLE next edge; the current vector is NOT counted; counters keep partial totals; no done pulse.
  - M all ones: exactly one vector, busy for 1 cycle.
  - M all zeros: 2^N_IN vectors; a maximum count of 32768 fits CNT_W=16 without wrap.
  - Counters saturate at all-ones; unreachable when CNT_W >= N_IN+1.
- Asserting rst in any state forces the reset values immediately; the partial sweep is discarded.
- Inputs fix_mask and fix_val are don't-care outside the start edge. f_in and g_in are sampled only in SWEEP.

Test Plan:
- Single vector: M=0x7FFF, V=0x1234, f=1, g=0, pulse start → x_out=0x1234; busy high 1 cycle; done next cycle; ones_cnt=1, mism_cnt=1.
- Two free LSBs: M=0x7FFC, V=0x0000, f=x0&x1, g=x0 → x_out sequence 0,1,2,3; busy 4 cycles; ones_cnt=1, mism_cnt=1.
- Non-contiguous free bits: M=0x7FFA, V=0x7FFF, f=x2 → x_out sequence 0x7FFA, 0x7FFB, 0x7FFE, 0x7FFF; ones_cnt=2, mism_cnt=0 with g=f.
- Full sweep: M=0x0000, f=x14, g=x14^x0 → busy 32768 cycles; ones_cnt=16384, mism_cnt=16384; single done pulse.
- Abort and re-start: M=0x7FF0, f=1, abort in the 5th busy cycle → IDLE; ones_cnt=4; no done. start asserted during busy in a separate run is ignored (sequence unaffected).
- Asynchronous reset mid-sweep: rst asserted between edges during a M=0x7F00 sweep → busy, done, x_out and counters go to 0 immediately. A new start after release runs a complete sweep: 256 vectors.

Source files
------------

// File: rtl/restriction_sweep_ctrl.sv
// Exhaustive-sweep sequencer: walks every input vector inside a restriction
// cube and counts f=1 hits and f/g disagreements.
module restriction_sweep_ctrl #(
  parameter int unsigned N_IN  = 15,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_IN-1:0]  fix_mask,
  input  logic [N_IN-1:0]  fix_val,
  output logic [N_IN-1:0]  x_out,
  input  logic             f_in,
  input  logic             g_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] mism_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   mask_q, mask_d;
  logic [N_IN-1:0]   val_q, val_d;
  logic [N_IN-1:0]   free_q, free_d;
  logic [N_IN-1:0]   x_d;
  logic [CNT_W-1:0]  ones_d, mism_d;
  logic [N_IN-1:0]   free_next;
  logic              last_vec;

  // Forcing fixed bits to 1 lets the carry ripple straight across them, so
  // the free bits count in ascending binary order.
  assign free_next = ((free_q | mask_q) + N_IN'(1)) & ~mask_q;
  assign last_vec  = (free_q == ~mask_q);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc);
    sat_inc = (inc && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
  endfunction

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    val_d   = val_q;
    free_d  = free_q;
    x_d     = x_out;
    ones_d  = ones_cnt;
    mism_d  = mism_cnt;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = fix_mask;
          val_d   = fix_val;
          free_d  = '0;
          ones_d  = '0;
          mism_d  = '0;
          x_d     = fix_val & fix_mask;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          ones_d = sat_inc(ones_cnt, f_in);
          mism_d = sat_inc(mism_cnt, f_in ^ g_in);
          if (last_vec) begin
            state_d = DONE;
          end else begin
            free_d = free_next;
            x_d    = free_next | (val_q & mask_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      val_q    <= '0;
      free_q   <= '0;
      x_out    <= '0;
      ones_cnt <= '0;
      mism_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      val_q    <= val_d;
      free_q   <= free_d;
      x_out    <= x_d;
      ones_cnt <= ones_d;
      mism_cnt <= mism_d;
      busy     <= (state_d == SWEEP);
      done     <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_restriction_sweep_ctrl.sv
// Self-checking bench for restriction_sweep_ctrl: a vector-list model of the
// restriction cube is checked against the DUT on every cycle of each sweep.
module tb_restriction_sweep_ctrl;

  localparam int unsigned N  = 15;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [N-1:0]  fix_mask;
  logic [N-1:0]  fix_val;
  logic [N-1:0]  x_out;
  logic          f_in;
  logic          g_in;
  logic          busy;
  logic          done;
  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] mism_cnt;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int expv[$];

  restriction_sweep_ctrl #(.N_IN(N), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .fix_mask (fix_mask),
    .fix_val  (fix_val),
    .x_out    (x_out),
    .f_in     (f_in),
    .g_in     (g_in),
    .busy     (busy),
    .done     (done),
    .ones_cnt (ones_cnt),
    .mism_cnt (mism_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Functions under test, selected per scenario.
  function automatic int model_f(input int md, input int x);
    case (md)
      0: return 1;
      1: return (x & 1) & ((x >> 1) & 1);
      2: return (x >> 2) & 1;
      3: return (x >> 14) & 1;
      default: return 1;
    endcase
  endfunction

  function automatic int model_g(input int md, input int x);
    case (md)
      0: return 0;
      1: return x & 1;
      2: return (x >> 2) & 1;
      3: return ((x >> 14) & 1) ^ (x & 1);
      default: return 1;
    endcase
  endfunction

  always_comb begin
    f_in = model_f(mode, int'(x_out)) != 0;
    g_in = model_g(mode, int'(x_out)) != 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One sweep from IDLE. abort_at / kill_at are vector indices (-1 = never);
  // kill_at leaves the DUT mid-sweep. both = abort high on the start edge,
  // noise = extra start pulses while busy and in DONE.
  task automatic run_sweep(input int m, input int v, input int md,
                           input int abort_at, input int kill_at,
                           input bit both, input bit noise,
                           output int ones_o, output int mism_o);
    int ones_m;
    int mism_m;
    mode = md;
    expv.delete();
    for (int x = 0; x < (1 << N); x++)
      if ((x & m) == (v & m)) expv.push_back(x);
    ones_m = 0;
    mism_m = 0;
    fix_mask = N'(m);
    fix_val  = N'(v);
    start    = 1'b1;
    abort    = both;
    @(posedge clk); #1;
    start    = 1'b0;
    abort    = 1'b0;
    fix_mask = ~fix_mask;
    fix_val  = ~fix_val;
    for (int i = 0; i < expv.size(); i++) begin
      check("busy_in_sweep", 32'(busy), 1);
      check("x_out_seq", 32'(x_out), expv[i]);
      check("done_in_sweep", 32'(done), 0);
      check("ones_running", 32'(ones_cnt), ones_m);
      check("mism_running", 32'(mism_cnt), mism_m);
      if (i == kill_at) begin
        ones_o = ones_m;
        mism_o = mism_m;
        return;
      end
      if (i == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("busy_after_abort", 32'(busy), 0);
        check("done_after_abort", 32'(done), 0);
        check("ones_after_abort", 32'(ones_cnt), ones_m);
        check("mism_after_abort", 32'(mism_cnt), mism_m);
        @(posedge clk); #1;
        check("no_done_after_abort", 32'(done), 0);
        check("idle_after_abort", 32'(busy), 0);
        ones_o = ones_m;
        mism_o = mism_m;
        return;
      end
      if (noise && i == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ones_m += model_f(md, expv[i]);
      mism_m += model_f(md, expv[i]) ^ model_g(md, expv[i]);
    end
    check("busy_end", 32'(busy), 0);
    check("done_pulse", 32'(done), 1);
    check("ones_final", 32'(ones_cnt), ones_m);
    check("mism_final", 32'(mism_cnt), mism_m);
    if (noise) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
    check("ones_hold", 32'(ones_cnt), ones_m);
    check("mism_hold", 32'(mism_cnt), mism_m);
    check("x_out_hold", 32'(x_out), expv[expv.size()-1]);
    ones_o = ones_m;
    mism_o = mism_m;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int o, mm;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    fix_mask = '0;
    fix_val  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_x_out", 32'(x_out), 0);
    check("rst_ones", 32'(ones_cnt), 0);
    check("rst_mism", 32'(mism_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single vector
    run_sweep(32'h7FFF, 32'h1234, 0, -1, -1, 1'b0, 1'b0, o, mm);
    check("single_x_out", 32'(x_out), 32'h1234);
    check("single_ones", o, 1);
    check("single_mism", mm, 1);

    // Two free LSBs, abort asserted together with start
    run_sweep(32'h7FFC, 32'h0000, 1, -1, -1, 1'b1, 1'b0, o, mm);
    check("two_nvec", expv.size(), 4);
    for (int k = 0; k < 4; k++) check("two_seq_model", expv[k], k);
    check("two_ones", o, 1);
    check("two_mism", mm, 1);

    // Non-contiguous free bits
    run_sweep(32'h7FFA, 32'h7FFF, 2, -1, -1, 1'b0, 1'b0, o, mm);
    check("nc_nvec", expv.size(), 4);
    check("nc_seq0", expv[0], 32'h7FFA);
    check("nc_seq1", expv[1], 32'h7FFB);
    check("nc_seq2", expv[2], 32'h7FFE);
    check("nc_seq3", expv[3], 32'h7FFF);
    check("nc_ones", o, 2);
    check("nc_mism", mm, 0);

    // Full sweep
    run_sweep(32'h0000, 32'h0000, 3, -1, -1, 1'b0, 1'b0, o, mm);
    check("full_nvec", expv.size(), 32768);
    check("full_ones", o, 16384);
    check("full_mism", mm, 16384);

    // Abort in the 5th busy cycle
    run_sweep(32'h7FF0, 32'h0005, 0, 4, -1, 1'b0, 1'b0, o, mm);
    check("abort_ones", o, 4);
    check("abort_ones_dut", 32'(ones_cnt), 4);

    // Start pulses while busy and in DONE are ignored
    run_sweep(32'h7FF0, 32'h2A50, 1, -1, -1, 1'b0, 1'b1, o, mm);
    check("noise_nvec", expv.size(), 16);

    // Asynchronous reset mid-sweep, then a complete 256-vector sweep
    run_sweep(32'h7F00, 32'h1200, 4, -1, 50, 1'b0, 1'b0, o, mm);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_x_out", 32'(x_out), 0);
    check("arst_ones", 32'(ones_cnt), 0);
    check("arst_mism", 32'(mism_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_sweep(32'h7F00, 32'h1200, 4, -1, -1, 1'b0, 1'b0, o, mm);
    check("rerun_nvec", expv.size(), 256);
    check("rerun_ones", o, 256);
    check("rerun_ones_dut", 32'(ones_cnt), 256);
    check("rerun_mism", mm, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
